// File: rtl/an_code_pkg.sv
// Shared AN-code helpers: Barrett constants, residue->error table entries and FSM states.
package an_code_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DETECT,
    ST_CORRECT,
    ST_OUT
  } state_e;

  localparam int SH_W = 6;

  typedef struct packed {
    logic            hit;
    logic            neg;
    logic [SH_W-1:0] sh;
  } corr_entry_t;

  function automatic int res_w(input int a);
    return $clog2(a);
  endfunction

  function automatic longint barrett_mu(input int a, input int cw_w);
    return (longint'(1) << cw_w) / longint'(a);
  endfunction

  // Residue r maps to +2^i when 2^i mod a == r, or to -2^i when a - (2^i mod a) == r.
  function automatic corr_entry_t corr_entry(input int a, input int cw_w, input int r);
    corr_entry_t e;
    int          p;
    e = '0;
    p = 1 % a;
    for (int i = 0; i < cw_w; i++) begin
      if (!e.hit && r != 0 && p == r) begin
        e.hit = 1'b1;
        e.neg = 1'b0;
        e.sh  = SH_W'(i);
      end else if (!e.hit && r != 0 && (a - p) == r) begin
        e.hit = 1'b1;
        e.neg = 1'b1;
        e.sh  = SH_W'(i);
      end
      p = (p * 2) % a;
    end
    return e;
  endfunction

endpackage

// File: rtl/an_grid_corrector_if.sv
// Frame-in / result-out handshake bundle for an_grid_corrector.
interface an_grid_corrector_if #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int CW_W  = 18,
  parameter int MSG_W = 13
);
  localparam int N = ROWS * COLS;

  logic               in_valid;
  logic               in_ready;
  logic [N*CW_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [N*MSG_W-1:0] out_data;
  logic [N-1:0]       out_err_map;
  logic               out_uncorr;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_map, out_uncorr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_map, out_uncorr
  );
endinterface

// File: rtl/an_barrett_lane.sv
// Combinational Barrett reduction of one AN codeword: quotient, residue and error flag.
module an_barrett_lane
  import an_code_pkg::*;
#(
  parameter int A     = 37,
  parameter int CW_W  = 18,
  parameter int MSG_W = 13,
  parameter int RES_W = res_w(A)
) (
  input  logic [CW_W-1:0]  x_i,
  output logic [MSG_W-1:0] q_o,
  output logic [RES_W-1:0] r_o,
  output logic             err_o
);
  localparam logic [CW_W-1:0] MU  = CW_W'(barrett_mu(A, CW_W));
  localparam logic [CW_W-1:0] A_W = CW_W'(A);

  logic [2*CW_W-1:0] prod;
  logic [CW_W-1:0]   q_hat;
  logic [CW_W-1:0]   r_hat;

  always_comb begin
    prod  = (2*CW_W)'(x_i) * (2*CW_W)'(MU);
    q_hat = CW_W'(prod >> CW_W);
    // r_hat < 2A, so modular arithmetic at CW_W bits is exact
    r_hat = x_i - q_hat * A_W;
    if (r_hat >= A_W) begin
      r_o = RES_W'(r_hat - A_W);
      q_o = MSG_W'(q_hat) + MSG_W'(1);
    end else begin
      r_o = RES_W'(r_hat);
      q_o = MSG_W'(q_hat);
    end
    err_o = |r_o;
  end

endmodule

// File: rtl/an_grid_corrector.sv
// Pipelined ROWSxCOLS AN decoder: parallel Barrett detect, shared one-lane-per-cycle corrector.
// Optional AN_ERR_STATS_EN adds saturating stat_frames / stat_corrected / stat_uncorr counters.
module an_grid_corrector
  import an_code_pkg::*;
#(
  parameter int ROWS     = 5,
  parameter int COLS     = 5,
  parameter int A        = 37,
  parameter int CW_W     = 18,
  parameter int MSG_W    = 13,
  parameter int MAX_CORR = ROWS * COLS
) (
  input logic clk,
  input logic rst,
  an_grid_corrector_if.slave bus
`ifdef AN_ERR_STATS_EN
  ,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_corrected,
  output logic [31:0] stat_uncorr
`endif
);
  // state      | meaning
  // IDLE       | in_ready=1, waiting for a frame
  // DETECT     | register Barrett q/r/err of all lanes
  // CORRECT    | fix lowest pending lane, one per cycle
  // OUT        | out_valid=1, hold until out_ready

  localparam int N     = ROWS * COLS;
  localparam int RES_W = res_w(A);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MAX_CORR + 1);
  localparam int TBL_N = 2 ** RES_W;

  state_e                    state_q, state_d;
  logic [N-1:0][CW_W-1:0]    data_q, data_d;
  logic [N-1:0][RES_W-1:0]   res_q, res_d;
  logic [N-1:0][MSG_W-1:0]   msg_q, msg_d;
  logic [N-1:0]              err_q, err_d;
  logic [N-1:0]              pend_q, pend_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      uncorr_q, uncorr_d;

  logic [N-1:0][MSG_W-1:0]   lane_q;
  logic [N-1:0][RES_W-1:0]   lane_r;
  logic [N-1:0]              lane_err;

  for (genvar n = 0; n < N; n++) begin : g_lane
    an_barrett_lane #(
      .A     (A),
      .CW_W  (CW_W),
      .MSG_W (MSG_W),
      .RES_W (RES_W)
    ) u_lane (
      .x_i   (data_q[n]),
      .q_o   (lane_q[n]),
      .r_o   (lane_r[n]),
      .err_o (lane_err[n])
    );
  end

  corr_entry_t tbl [TBL_N];

  for (genvar j = 0; j < TBL_N; j++) begin : g_tbl
    localparam corr_entry_t ENT = corr_entry(A, CW_W, j);
    assign tbl[j] = ENT;
  end

  logic [IDX_W-1:0] sel;
  logic [CW_W-1:0]  sel_x;
  corr_entry_t      ent;
  logic [CW_W:0]    pow;
  logic [CW_W:0]    x_adj;
  logic [MSG_W-1:0] m_fix;

  // Shared corrector: lowest-index pending lane, table lookup, remove error, divide by A
  always_comb begin
    sel = '0;
    for (int n = N - 1; n >= 0; n--) begin
      if (pend_q[n]) sel = IDX_W'(n);
    end
    sel_x = data_q[sel];
    ent   = tbl[res_q[sel]];
    pow   = (CW_W+1)'(1) << ent.sh;
    x_adj = ent.neg ? ({1'b0, sel_x} + pow) : ({1'b0, sel_x} - pow);
    m_fix = MSG_W'(x_adj / (CW_W+1)'(A));
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    res_d         = res_q;
    msg_d         = msg_q;
    err_d         = err_q;
    pend_d        = pend_q;
    cnt_d         = cnt_q;
    uncorr_d      = uncorr_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          state_d = ST_DETECT;
        end
      end
      ST_DETECT: begin
        res_d    = lane_r;
        msg_d    = lane_q;
        err_d    = lane_err;
        pend_d   = lane_err;
        cnt_d    = '0;
        uncorr_d = 1'b0;
        state_d  = (|lane_err) ? ST_CORRECT : ST_OUT;
      end
      ST_CORRECT: begin
        pend_d[sel] = 1'b0;
        cnt_d       = cnt_q + CNT_W'(1);
        if (ent.hit) msg_d[sel] = m_fix;
        else         uncorr_d   = 1'b1;
        if (pend_d == '0) begin
          state_d = ST_OUT;
        end else if (cnt_d == CNT_W'(MAX_CORR)) begin
          // budget spent: remaining flagged lanes keep their Barrett quotient
          uncorr_d = 1'b1;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      res_q    <= '0;
      msg_q    <= '0;
      err_q    <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      uncorr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      res_q    <= res_d;
      msg_q    <= msg_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign bus.out_data    = msg_q;
  assign bus.out_err_map = err_q;
  assign bus.out_uncorr  = uncorr_q;

`ifdef AN_ERR_STATS_EN
  logic [31:0] frames_q, corr_q, unc_q;
  logic        out_hs;

  assign out_hs = (state_q == ST_OUT) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      corr_q   <= '0;
      unc_q    <= '0;
    end else begin
      if (out_hs && frames_q != '1) frames_q <= frames_q + 32'd1;
      if (out_hs && uncorr_q && unc_q != '1) unc_q <= unc_q + 32'd1;
      if (state_q == ST_CORRECT && ent.hit && corr_q != '1) corr_q <= corr_q + 32'd1;
    end
  end

  assign stat_frames    = frames_q;
  assign stat_corrected = corr_q;
  assign stat_uncorr    = unc_q;
`endif

endmodule

// File: tb/tb_an_grid_corrector.sv
// Directed-vector bench for an_grid_corrector: default build and a MAX_CORR=1 instance.
module tb_an_grid_corrector;
  localparam int N  = 25;
  localparam int CW = 18;
  localparam int MW = 13;

  typedef logic [N*CW-1:0] frame_t;
  typedef logic [N*MW-1:0] vec_t;

  logic   clk;
  logic   rst;
  logic   sel;
  frame_t frame;
  logic   v0, v1, ordy;
  int     n_vec = 0;
  int     n_err = 0;

  an_grid_corrector_if #(.ROWS(5), .COLS(5), .CW_W(CW), .MSG_W(MW)) bus0 ();
  an_grid_corrector_if #(.ROWS(5), .COLS(5), .CW_W(CW), .MSG_W(MW)) bus1 ();

  assign bus0.in_valid  = v0;
  assign bus1.in_valid  = v1;
  assign bus0.in_data   = frame;
  assign bus1.in_data   = frame;
  assign bus0.out_ready = ordy;
  assign bus1.out_ready = ordy;

`ifdef AN_ERR_STATS_EN
  logic [31:0] sf0, sc0, su0, sf1, sc1, su1;
`endif

  an_grid_corrector #(.ROWS(5), .COLS(5), .A(37), .CW_W(CW), .MSG_W(MW), .MAX_CORR(25)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
`ifdef AN_ERR_STATS_EN
    , .stat_frames(sf0), .stat_corrected(sc0), .stat_uncorr(su0)
`endif
  );

  an_grid_corrector #(.ROWS(5), .COLS(5), .A(37), .CW_W(CW), .MSG_W(MW), .MAX_CORR(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef AN_ERR_STATS_EN
    , .stat_frames(sf1), .stat_corrected(sc1), .stat_uncorr(su1)
`endif
  );

  logic         o_in_ready, o_out_valid, o_uncorr;
  vec_t         o_data;
  logic [N-1:0] o_err;

  assign o_in_ready  = sel ? bus1.in_ready    : bus0.in_ready;
  assign o_out_valid = sel ? bus1.out_valid   : bus0.out_valid;
  assign o_data      = sel ? bus1.out_data    : bus0.out_data;
  assign o_err       = sel ? bus1.out_err_map : bus0.out_err_map;
  assign o_uncorr    = sel ? bus1.out_uncorr  : bus0.out_uncorr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t frame_all(input int v);
    frame_t f;
    for (int n = 0; n < N; n++) f[n*CW +: CW] = CW'(v);
    return f;
  endfunction

  function automatic vec_t msgs_all(input int v);
    vec_t e;
    for (int n = 0; n < N; n++) e[n*MW +: MW] = MW'(v);
    return e;
  endfunction

  // Called #1 after a posedge with the selected DUT idle; returns in the out_valid cycle.
  task automatic run_frame(input logic s, input frame_t f, output int lat);
    sel   = s;
    frame = f;
    if (s) v1 = 1'b1;
    else   v0 = 1'b1;
    #0;
    chk("in_ready_at_offer", vec_t'(o_in_ready), vec_t'(1'b1));
    @(posedge clk);
    #1;
    v0  = 1'b0;
    v1  = 1'b0;
    lat = 1;
    while (!o_out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic expect_frame(input string tag, input int lat, input int exp_lat,
                              input vec_t exp_data, input logic [N-1:0] exp_err,
                              input logic exp_unc);
    chk({tag, "_latency"}, vec_t'(lat), vec_t'(exp_lat));
    chk({tag, "_data"},    o_data, exp_data);
    chk({tag, "_errmap"},  vec_t'(o_err), vec_t'(exp_err));
    chk({tag, "_uncorr"},  vec_t'(o_uncorr), vec_t'(exp_unc));
  endtask

  task automatic finish_out(input string tag);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_ready_after"}, vec_t'(o_in_ready), vec_t'(1'b1));
    chk({tag, "_valid_after"}, vec_t'(o_out_valid), vec_t'(1'b0));
  endtask

  initial begin
    frame_t       f3, f4;
    vec_t         e4, held;
    logic [N-1:0] m;
    int           lat;

    rst = 1'b1; sel = 1'b0; frame = '0; v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  vec_t'(o_in_ready),  vec_t'(1'b1));
    chk("rst_out_valid", vec_t'(o_out_valid), vec_t'(1'b0));
    chk("rst_out_data",  o_data,              vec_t'(0));
    chk("rst_err_map",   vec_t'(o_err),       vec_t'(0));
    chk("rst_uncorr",    vec_t'(o_uncorr),    vec_t'(0));

    // clean frame
    run_frame(1'b0, frame_all(3700), lat);
    expect_frame("clean", lat, 2, msgs_all(100), '0, 1'b0);
    finish_out("clean");

    // single +8 error on lane 7
    f3 = frame_all(3700);
    f3[7*CW +: CW] = 18'd3708;
    run_frame(1'b0, f3, lat);
    m = '0; m[7] = 1'b1;
    expect_frame("lane7", lat, 3, msgs_all(100), m, 1'b0);
    finish_out("lane7");

    // three errors: -1, +16, +1
    f3 = frame_all(3700);
    f3[0*CW +: CW]  = 18'd3699;
    f3[12*CW +: CW] = 18'd3716;
    f3[24*CW +: CW] = 18'd3701;
    run_frame(1'b0, f3, lat);
    m = '0; m[0] = 1'b1; m[12] = 1'b1; m[24] = 1'b1;
    expect_frame("three", lat, 5, msgs_all(100), m, 1'b0);
    finish_out("three");

    // distinct messages per lane, +2^17 on lane 5, -2^10 on lane 20
    for (int n = 0; n < N; n++) begin
      f4[n*CW +: CW] = CW'(37 * (n * 283 + 5));
      e4[n*MW +: MW] = MW'(n * 283 + 5);
    end
    f4[5*CW +: CW]  = 18'd183612;
    f4[20*CW +: CW] = 18'd208581;
    run_frame(1'b0, f4, lat);
    m = '0; m[5] = 1'b1; m[20] = 1'b1;
    expect_frame("spread", lat, 4, e4, m, 1'b0);
    finish_out("spread");

    // MAX_CORR=1 instance: second flagged lane stays at q
    f3 = frame_all(3700);
    f3[0*CW +: CW] = 18'd3701;
    f3[3*CW +: CW] = 18'd3701;
    run_frame(1'b1, f3, lat);
    m = '0; m[0] = 1'b1; m[3] = 1'b1;
    expect_frame("maxcorr1", lat, 3, msgs_all(100), m, 1'b1);
    finish_out("maxcorr1");
    sel = 1'b0;

    // consumer back-pressure for 4 cycles
    ordy = 1'b0;
    f3 = frame_all(3700);
    f3[1*CW +: CW] = 18'd3702;
    run_frame(1'b0, f3, lat);
    m = '0; m[1] = 1'b1;
    expect_frame("stall", lat, 3, msgs_all(100), m, 1'b0);
    held = msgs_all(100);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid_held", vec_t'(o_out_valid), vec_t'(1'b1));
      chk("stall_in_ready",   vec_t'(o_in_ready),  vec_t'(1'b0));
      chk("stall_data_held",  o_data,              held);
    end
    finish_out("stall");
    run_frame(1'b0, frame_all(3700), lat);
    expect_frame("after_stall", lat, 2, msgs_all(100), '0, 1'b0);
    finish_out("after_stall");

    // reset while in CORRECT
    f3 = frame_all(3700);
    f3[0*CW +: CW]  = 18'd3699;
    f3[12*CW +: CW] = 18'd3716;
    f3[24*CW +: CW] = 18'd3701;
    frame = f3;
    v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_pre_valid", vec_t'(o_out_valid), vec_t'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", vec_t'(o_out_valid), vec_t'(1'b0));
    chk("midrst_in_ready",  vec_t'(o_in_ready),  vec_t'(1'b1));
    chk("midrst_out_data",  o_data,              vec_t'(0));
    chk("midrst_err_map",   vec_t'(o_err),       vec_t'(0));
    run_frame(1'b0, f4, lat);
    m = '0; m[5] = 1'b1; m[20] = 1'b1;
    expect_frame("post_rst", lat, 4, e4, m, 1'b0);
    finish_out("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
